// File: rtl/uart_tx_pb.sv
// PicoBlaze UART transmit engine: pops the TX FIFO and shifts each byte
// out as an 8N1/8N2 frame, LSB first, timed by an oversampled baud tick.
module uart_tx_pb #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] uart_clock_divide,
  input  logic [7:0]  tx_fifo_data,
  input  logic        tx_data_present,
  output logic        tx_buffer_read,
  output logic        serial_out,
  output logic        busy,
  output logic        tx_done
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [15:0]   div_l;
  logic [15:0]   baud_cnt;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic          stop_cnt;
  logic [7:0]    shift;
  logic          tick;
  logic          bit_end;

  assign tick    = (baud_cnt == div_l);
  assign bit_end = tick && (tick_cnt == LAST_TICK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      div_l          <= '0;
      baud_cnt       <= '0;
      tick_cnt       <= '0;
      bit_idx        <= '0;
      stop_cnt       <= 1'b0;
      shift          <= '0;
      tx_buffer_read <= 1'b0;
      serial_out     <= 1'b1;
      busy           <= 1'b0;
      tx_done        <= 1'b0;
    end else begin
      tx_buffer_read <= 1'b0;
      tx_done        <= 1'b0;
      // counters wrap on their own, so they are already zero at frame end
      if (state != IDLE) begin
        baud_cnt <= tick ? '0 : baud_cnt + 16'd1;
        if (tick)
          tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          serial_out <= 1'b1;
          busy       <= 1'b0;
          if (enable && tx_data_present) begin
            shift          <= tx_fifo_data;
            div_l          <= uart_clock_divide;
            serial_out     <= 1'b0;
            busy           <= 1'b1;
            tx_buffer_read <= 1'b1;
            baud_cnt       <= '0;
            tick_cnt       <= '0;
            bit_idx        <= '0;
            stop_cnt       <= 1'b0;
            state          <= START;
          end
        end
        START: begin
          if (bit_end) begin
            serial_out <= shift[0];
            state      <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              serial_out <= 1'b1;
              state      <= STOP;
            end else begin
              shift      <= {1'b0, shift[7:1]};
              serial_out <= shift[1];
              bit_idx    <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_cnt == LAST_STOP) begin
              tx_done <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_pb.sv
// Bench for uart_tx_pb: FIFO model, frame-level reference of the
// expected TXD waveform, and directed plus randomized traffic.
module tb_uart_tx_pb;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] div;
  logic [7:0]  data1;
  logic        present1;
  logic        rd1, so1, busy1, done1;
  logic [7:0]  data2;
  logic        present2;
  logic        rd2, so2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int pops1  = 0;
  int pops2  = 0;

  logic [7:0] q[$];
  logic [7:0] exp_q[$];

  uart_tx_pb #(.OVERSAMPLE(16), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .uart_clock_divide(div),
    .tx_fifo_data(data1), .tx_data_present(present1),
    .tx_buffer_read(rd1), .serial_out(so1),
    .busy(busy1), .tx_done(done1)
  );

  uart_tx_pb #(.OVERSAMPLE(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable),
    .uart_clock_divide(div),
    .tx_fifo_data(data2), .tx_data_present(present2),
    .tx_buffer_read(rd2), .serial_out(so2),
    .busy(busy2), .tx_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_upd();
    present1 = (q.size() != 0);
    data1    = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // advance to the next negedge and let the FIFO models react to pops
  task automatic step();
    @(negedge clk);
    if (rd1 === 1'b1) begin
      pops1++;
      if (q.size() != 0) q.delete(0);
    end
    if (rd2 === 1'b1) begin
      pops2++;
      present2 = 1'b0;
    end
    fifo_upd();
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    exp_q.push_back(b);
    fifo_upd();
  endtask

  function automatic logic line(input bit sel);
    return sel ? so2 : so1;
  endfunction
  function automatic logic bsy(input bit sel);
    return sel ? busy2 : busy1;
  endfunction
  function automatic logic dn(input bit sel);
    return sel ? done2 : done1;
  endfunction
  function automatic logic rdx(input bit sel);
    return sel ? rd2 : rd1;
  endfunction

  // expected line level for frame bit k: start, 8 data LSB first, stops
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic rx_frame(input bit sel, input logic [7:0] exp_b,
                          input int d, input int nstop, input int max_wait);
    int p, f, n, k, strobes, busy_bad, done_bad;
    int bad[11];
    logic [7:0] got;
    p = 16 * (d + 1);
    f = p * (9 + nstop);
    n = 0;
    got = 8'h00;
    strobes = 0;
    busy_bad = 0;
    done_bad = 0;
    for (int i = 0; i < 11; i++) bad[i] = 0;
    while (line(sel) !== 1'b0 && n <= max_wait) begin
      step();
      n++;
    end
    chk("start_latency_ok", 32'(n <= max_wait), 1);
    if (n > max_wait) return;
    for (int c = 0; c < f; c++) begin
      if (c > 0) step();
      k = c / p;
      if (line(sel) !== frame_bit(exp_b, k)) bad[k]++;
      if (bsy(sel) !== 1'b1) busy_bad++;
      if (dn(sel) !== 1'b0) done_bad++;
      if (rdx(sel) === 1'b1) strobes++;
      if (k >= 1 && k <= 8 && (c % p) == p / 2) got[k-1] = line(sel);
    end
    for (int i = 0; i < 9 + nstop; i++)
      chk($sformatf("bit%0d_bad_clks", i), bad[i], 0);
    chk("decoded_byte", got, exp_b);
    chk("busy_low_in_frame", busy_bad, 0);
    chk("done_early", done_bad, 0);
    chk("pop_strobes", strobes, 1);
    step();
    chk("tx_done_pulse", dn(sel), 1);
    chk("busy_after", bsy(sel), 0);
    chk("gap_high", line(sel), 1);
  endtask

  initial begin
    int base, hi_bad, rd_bad, nb, d, n;
    reset    = 1'b1;
    enable   = 1'b0;
    div      = 16'd0;
    present2 = 1'b0;
    data2    = 8'h00;
    fifo_upd();
    step();
    step();
    chk("rst_serial", so1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_rd", rd1, 0);
    chk("rst_done", done1, 0);
    reset = 1'b0;
    step();

    // 1: single 8N1 frame, div 0
    enable = 1'b1;
    push(8'hA5);
    rx_frame(0, exp_q.pop_front(), 0, 1, 1);
    chk("pops_t1", pops1, 1);

    // 2: back-to-back at div 3
    div = 16'd3;
    push(8'h00);
    push(8'hFF);
    rx_frame(0, exp_q.pop_front(), 3, 1, 1);
    rx_frame(0, exp_q.pop_front(), 3, 1, 1);
    step();
    chk("pops_t2", pops1, 3);

    // 3: enable gating
    div = 16'd0;
    enable = 1'b0;
    push(8'($urandom));
    hi_bad = 0;
    rd_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (so1 !== 1'b1) hi_bad++;
      if (rd1 !== 1'b0) rd_bad++;
    end
    chk("dis_line_high", hi_bad, 0);
    chk("dis_no_pop", rd_bad, 0);
    enable = 1'b1;
    rx_frame(0, exp_q.pop_front(), 0, 1, 1);
    push(8'($urandom));
    push(8'($urandom));
    fork
      begin
        repeat (60) @(negedge clk);
        enable = 1'b0;
      end
    join_none
    rx_frame(0, exp_q.pop_front(), 0, 1, 1);
    hi_bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (so1 !== 1'b1 || busy1 !== 1'b0) hi_bad++;
    end
    chk("stopped_after_disable", hi_bad, 0);
    chk("fifo_left", q.size(), 1);
    enable = 1'b1;
    rx_frame(0, exp_q.pop_front(), 0, 1, 1);

    // 4: divider change mid-frame
    push(8'($urandom));
    fork
      begin
        repeat (40) @(negedge clk);
        div = 16'd7;
      end
    join_none
    rx_frame(0, exp_q.pop_front(), 0, 1, 1);
    push(8'($urandom));
    rx_frame(0, exp_q.pop_front(), 7, 1, 1);

    // 5: reset during data bit 4
    div = 16'd0;
    step();
    base = pops1;
    push(8'($urandom));
    push(8'($urandom));
    n = 0;
    while (so1 !== 1'b0 && n < 5) begin
      step();
      n++;
    end
    chk("t5_started", so1, 0);
    repeat (5 * 16 + 8) step();
    reset = 1'b1;
    #1;
    chk("mid_rst_serial", so1, 1);
    chk("mid_rst_busy", busy1, 0);
    void'(exp_q.pop_front());
    step();
    step();
    chk("rst_no_pop", pops1, base + 1);
    reset = 1'b0;
    rx_frame(0, exp_q.pop_front(), 0, 1, 1);
    step();
    chk("pops_t5", pops1, base + 2);

    // randomized batches
    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(0, 2);
      div = 16'(d);
      nb = $urandom_range(2, 4);
      for (int i = 0; i < nb; i++) push(8'($urandom));
      for (int i = 0; i < nb; i++)
        rx_frame(0, exp_q.pop_front(), d, 1, 1);
      step();
    end
    chk("fifo_drained", q.size(), 0);

    // 6: two stop bits
    div = 16'd0;
    data2 = 8'h3C;
    present2 = 1'b1;
    rx_frame(1, 8'h3C, 0, 2, 1);
    step();
    chk("pops_dut2", pops2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
